// File: rtl/sprite_linebuf_pkg.sv
// Shared defaults and write-FSM encoding for the double-buffered sprite line buffer.
package sprite_linebuf_pkg;

  localparam int         DW_DEF     = 8;
  localparam int         AW_DEF     = 9;
  localparam logic [7:0] TRANSP_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT
  } wr_state_e;

endpackage

// File: rtl/sprite_linebuf_ram.sv
// One line-buffer bank: 2^AW x DW simple dual-port RAM with a registered read port.
module sprite_linebuf_ram
  import sprite_linebuf_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  // Read-before-write on an address collision; the top never relies on either order.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: display bank is read and erased behind the beam,
// draw bank takes first-opaque-wins writes; banks swap on each HBLK rising edge.
module sprite_linebuf
  import sprite_linebuf_pkg::*;
#(
  parameter int            DW     = DW_DEF,
  parameter int            AW     = AW_DEF,
  parameter logic [DW-1:0] TRANSP = TRANSP_DEF
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          PCLK_EN,
  input  logic [AW-1:0] HPOS,
  input  logic          HBLK,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [AW-1:0] WR_X,
  input  logic [DW-1:0] WR_D,
  output logic [DW-1:0] PIX_OUT,
  output logic          PIX_OPQ,
  output logic          LINE_SWAP,
  output logic          INIT_DONE
);

  wr_state_e     state_q, state_d;
  logic          sel_q, sel_d;
  logic          hblk_q;
  logic          line_swap_q;
  logic          init_done_q, init_done_d;
  logic          wr_ready_q, wr_ready_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic [AW-1:0] x_q, x_d;
  logic [DW-1:0] col_q, col_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] pix_out_q, pix_out_d;
  logic          pix_opq_q, pix_opq_d;

  logic          swap;
  logic          rd_req;
  logic          blank_px;
  logic          accept;
  logic          commit_we;
  logic [DW-1:0] bank_rd_data [2];
  logic [DW-1:0] disp_rd_data;
  logic [DW-1:0] draw_rd_data;

  assign swap         = init_done_q && HBLK && !hblk_q;
  assign rd_req       = init_done_q && PCLK_EN && !HBLK;
  assign blank_px     = init_done_q && PCLK_EN && HBLK;
  assign accept       = (state_q == ST_IDLE) && WR_VALID && wr_ready_q && !swap;
  assign disp_rd_data = bank_rd_data[sel_q];
  assign draw_rd_data = bank_rd_data[!sel_q];

  // FSM state register
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // FSM next state; a swap abandons any in-flight draw.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   if (init_addr_q == {AW{1'b1}}) state_d = ST_IDLE;
      ST_IDLE:   if (accept && (WR_D != TRANSP)) state_d = ST_CHECK;
      ST_CHECK:  state_d = swap ? ST_IDLE : ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_ready_d  = (state_d == ST_IDLE) && !swap;
    init_done_d = init_done_q || ((state_q == ST_INIT) && (init_addr_q == {AW{1'b1}}));
    init_addr_d = (state_q == ST_INIT) ? init_addr_q + 1'b1 : init_addr_q;
    x_d         = accept ? WR_X : x_q;
    col_d       = accept ? WR_D : col_q;
    commit_we   = (state_q == ST_COMMIT) && !swap && (draw_rd_data == TRANSP);
  end

  // Pixel readout and bank select
  always_comb begin
    sel_d     = swap ? !sel_q : sel_q;
    rd_pend_d = rd_req;
    rd_addr_d = rd_req ? HPOS : rd_addr_q;
    pix_out_d = pix_out_q;
    if (rd_pend_q)     pix_out_d = disp_rd_data;
    else if (blank_px) pix_out_d = TRANSP;
    pix_opq_d = (pix_out_d != TRANSP);
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_q       <= 1'b0;
      hblk_q      <= 1'b1;
      line_swap_q <= 1'b0;
      init_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      init_addr_q <= '0;
      x_q         <= '0;
      col_q       <= TRANSP;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      pix_out_q   <= TRANSP;
      pix_opq_q   <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      hblk_q      <= HBLK;
      line_swap_q <= swap;
      init_done_q <= init_done_d;
      wr_ready_q  <= wr_ready_d;
      init_addr_q <= init_addr_d;
      x_q         <= x_d;
      col_q       <= col_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      pix_out_q   <= pix_out_d;
      pix_opq_q   <= pix_opq_d;
    end
  end

  // Bank port muxing: bank gi is the display bank when sel_q == gi, else the draw bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic          is_disp;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign is_disp = (sel_q == 1'(gi));

    always_comb begin
      rd_en   = 1'b0;
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = TRANSP;
      if (state_q == ST_INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_addr_q;
      end else if (is_disp) begin
        rd_en   = rd_req;
        rd_addr = HPOS;
        wr_en   = rd_pend_q;
        wr_addr = rd_addr_q;
      end else begin
        rd_en   = (state_q == ST_CHECK);
        rd_addr = x_q;
        wr_en   = commit_we;
        wr_addr = x_q;
        wr_data = col_q;
      end
    end

    sprite_linebuf_ram #(
      .AW(AW),
      .DW(DW)
    ) u_ram (
      .clk    (MCLK),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(bank_rd_data[gi]),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data)
    );
  end

  assign WR_READY  = wr_ready_q;
  assign PIX_OUT   = pix_out_q;
  assign PIX_OPQ   = pix_opq_q;
  assign LINE_SWAP = line_swap_q;
  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Directed bench for sprite_linebuf: init, draw/readout, priority, erase, swap-drop, reset.
module tb_sprite_linebuf;

  logic       MCLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       PCLK_EN = 1'b0;
  logic [8:0] HPOS = '0;
  logic       HBLK = 1'b0;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [8:0] WR_X = '0;
  logic [7:0] WR_D = '0;
  logic [7:0] PIX_OUT;
  logic       PIX_OPQ;
  logic       LINE_SWAP;
  logic       INIT_DONE;

  int tests = 0;
  int fails = 0;

  sprite_linebuf dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .PCLK_EN(PCLK_EN), .HPOS(HPOS), .HBLK(HBLK),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_X(WR_X), .WR_D(WR_D),
    .PIX_OUT(PIX_OUT), .PIX_OPQ(PIX_OPQ), .LINE_SWAP(LINE_SWAP), .INIT_DONE(INIT_DONE)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One pixel readout: mid is PIX_OUT one cycle after the PCLK_EN edge, pix/opq after two.
  task automatic pulse_px(input logic [8:0] h, output logic [7:0] mid,
                          output logic [7:0] pix, output logic opq);
    HPOS = h;
    PCLK_EN = 1'b1;
    @(negedge MCLK);
    PCLK_EN = 1'b0;
    mid = PIX_OUT;
    @(negedge MCLK);
    pix = PIX_OUT;
    opq = PIX_OPQ;
  endtask

  // Offer one write and check the WR_READY pattern that follows the accept.
  task automatic do_write(input logic [8:0] x, input logic [7:0] d);
    int n = 0;
    while (WR_READY !== 1'b1 && n < 20) begin
      @(negedge MCLK);
      n++;
    end
    tests++;
    if (n == 20) begin
      fails++;
      $display("FAIL write_ready_timeout x=%0d WR_READY=%b want 1", x, WR_READY);
    end
    WR_VALID = 1'b1; WR_X = x; WR_D = d;
    @(negedge MCLK);
    WR_VALID = 1'b0;
    tests++;
    if (WR_READY !== (d == 8'hFF)) begin
      fails++;
      $display("FAIL write_ready_c1 x=%0d d=%h WR_READY=%b want %b", x, d, WR_READY, d == 8'hFF);
    end
    if (d != 8'hFF) begin
      @(negedge MCLK);
      tests++;
      if (WR_READY !== 1'b0) begin
        fails++;
        $display("FAIL write_ready_c2 x=%0d WR_READY=%b want 0", x, WR_READY);
      end
      @(negedge MCLK);
      tests++;
      if (WR_READY !== 1'b1) begin
        fails++;
        $display("FAIL write_ready_c3 x=%0d WR_READY=%b want 1", x, WR_READY);
      end
    end
    $display("[TB] write x=%0d d=%h", x, d);
  endtask

  // HBLK rise with a blanked pixel pulse; checks the one-cycle LINE_SWAP.
  task automatic do_swap(input bit check_blank);
    HBLK = 1'b1;
    @(negedge MCLK);
    tests++;
    if (LINE_SWAP !== 1'b1) begin
      fails++;
      $display("FAIL swap_pulse LINE_SWAP=%b want 1", LINE_SWAP);
    end
    PCLK_EN = 1'b1;
    HPOS = 9'd0;
    @(negedge MCLK);
    PCLK_EN = 1'b0;
    tests++;
    if (LINE_SWAP !== 1'b0) begin
      fails++;
      $display("FAIL swap_pulse_end LINE_SWAP=%b want 0", LINE_SWAP);
    end
    @(negedge MCLK);
    if (check_blank) begin
      tests++;
      if (PIX_OUT !== 8'hFF || PIX_OPQ !== 1'b0) begin
        fails++;
        $display("FAIL blank_px PIX_OUT=%h PIX_OPQ=%b want ff/0", PIX_OUT, PIX_OPQ);
      end
    end
    HBLK = 1'b0;
    @(negedge MCLK);
    $display("[TB] swap");
  endtask

  task automatic test_reset;
    int bad = 0;
    #1 RESET_N = 1'b0;
    #1;
    tests++;
    if (PIX_OUT !== 8'hFF || PIX_OPQ !== 1'b0 || WR_READY !== 1'b0 ||
        LINE_SWAP !== 1'b0 || INIT_DONE !== 1'b0) begin
      fails++;
      $display("FAIL reset_values pix=%h opq=%b rdy=%b swp=%b done=%b want ff/0/0/0/0",
               PIX_OUT, PIX_OPQ, WR_READY, LINE_SWAP, INIT_DONE);
    end
    @(negedge MCLK);
    RESET_N = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(negedge MCLK);
      if (k < 512) begin
        if (WR_READY !== 1'b0 || INIT_DONE !== 1'b0 || PIX_OUT !== 8'hFF || LINE_SWAP !== 1'b0) begin
          if (bad == 0)
            $display("FAIL init_busy k=%0d rdy=%b done=%b pix=%h swp=%b want 0/0/ff/0",
                     k, WR_READY, INIT_DONE, PIX_OUT, LINE_SWAP);
          bad++;
        end
      end else begin
        tests++;
        if (WR_READY !== 1'b1 || INIT_DONE !== 1'b1) begin
          fails++;
          $display("FAIL init_done k=%0d rdy=%b done=%b want 1/1", k, WR_READY, INIT_DONE);
        end
      end
      PCLK_EN = (k % 4 == 0) && (k < 500);
      HPOS    = 9'(k);
      HBLK    = (k >= 100) && (k < 104);
    end
    tests++;
    if (bad != 0) fails++;
    PCLK_EN = 1'b0;
    HBLK = 1'b0;
    $display("[TB] reset/init complete, busy-phase violations=%0d", bad);
  endtask

  task automatic test_blank_line;
    logic [7:0] mid, pix;
    logic opq;
    int bad = 0;
    for (int h = 0; h < 512; h++) begin
      pulse_px(9'(h), mid, pix, opq);
      if (pix !== 8'hFF || opq !== 1'b0) begin
        if (bad == 0) $display("FAIL blank_line h=%0d got %h/%b want ff/0", h, pix, opq);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    $display("[TB] full line readout, bad pixels=%0d", bad);
  endtask

  task automatic test_basic_write;
    logic [8:0] hs [4] = '{9'd99, 9'd100, 9'd101, 9'd0};
    logic [7:0] ex [4] = '{8'hFF, 8'h23, 8'hFF, 8'hFF};
    logic [7:0] mid, pix;
    logic opq;
    do_write(9'd100, 8'h23);
    do_swap(1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse_px(hs[i], mid, pix, opq);
      tests++;
      if (pix !== ex[i] || opq !== (ex[i] != 8'hFF)) begin
        fails++;
        $display("FAIL basic_px h=%0d got %h/%b want %h/%b", hs[i], pix, opq, ex[i], ex[i] != 8'hFF);
      end
      if (hs[i] == 9'd100) begin
        tests++;
        if (mid !== 8'hFF) begin
          fails++;
          $display("FAIL basic_latency h=100 early PIX_OUT=%h want ff", mid);
        end
        @(negedge MCLK);
        tests++;
        if (PIX_OUT !== 8'h23) begin
          fails++;
          $display("FAIL basic_hold PIX_OUT=%h want 23", PIX_OUT);
        end
      end
      $display("[TB] px h=%0d -> %h/%b", hs[i], pix, opq);
    end
  endtask

  task automatic test_priority;
    logic [8:0] hs [3] = '{9'd49, 9'd50, 9'd60};
    logic [7:0] ex [3] = '{8'hFF, 8'h11, 8'h33};
    logic [7:0] mid, pix;
    logic opq;
    do_write(9'd50, 8'h11);
    do_write(9'd50, 8'h22);
    do_write(9'd60, 8'h33);
    do_write(9'd60, 8'hFF);
    do_swap(1'b1);
    for (int i = 0; i < 3; i++) begin
      pulse_px(hs[i], mid, pix, opq);
      tests++;
      if (pix !== ex[i] || opq !== (ex[i] != 8'hFF)) begin
        fails++;
        $display("FAIL priority_px h=%0d got %h/%b want %h/%b", hs[i], pix, opq, ex[i], ex[i] != 8'hFF);
      end
      $display("[TB] px h=%0d -> %h/%b", hs[i], pix, opq);
    end
  endtask

  task automatic test_erase;
    logic [7:0] mid, pix;
    logic opq;
    do_swap(1'b1);
    pulse_px(9'd100, mid, pix, opq);
    tests++;
    if (pix !== 8'hFF || opq !== 1'b0) begin
      fails++;
      $display("FAIL erase_px h=100 got %h/%b want ff/0", pix, opq);
    end
    $display("[TB] px h=100 -> %h/%b (after erase)", pix, opq);
  endtask

  task automatic test_swap_drop;
    logic [8:0] hs [4] = '{9'd80, 9'd100, 9'd50, 9'd90};
    logic [7:0] ex [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h5A};
    logic [7:0] mid, pix;
    logic opq;
    int n = 0;
    while (WR_READY !== 1'b1 && n < 20) begin
      @(negedge MCLK);
      n++;
    end
    WR_VALID = 1'b1; WR_X = 9'd70; WR_D = 8'h44;
    @(negedge MCLK);
    WR_VALID = 1'b0;
    HBLK = 1'b1;
    tests++;
    if (WR_READY !== 1'b0) begin
      fails++;
      $display("FAIL drop_check_ready WR_READY=%b want 0", WR_READY);
    end
    @(negedge MCLK);
    tests++;
    if (LINE_SWAP !== 1'b1 || WR_READY !== 1'b0) begin
      fails++;
      $display("FAIL drop_swap_cycle swp=%b rdy=%b want 1/0", LINE_SWAP, WR_READY);
    end
    WR_VALID = 1'b1; WR_X = 9'd80; WR_D = 8'h55;
    @(negedge MCLK);
    WR_VALID = 1'b0;
    HBLK = 1'b0;
    tests++;
    if (WR_READY !== 1'b1 || LINE_SWAP !== 1'b0) begin
      fails++;
      $display("FAIL drop_after_swap rdy=%b swp=%b want 1/0", WR_READY, LINE_SWAP);
    end
    @(negedge MCLK);
    pulse_px(9'd70, mid, pix, opq);
    tests++;
    if (pix !== 8'hFF || opq !== 1'b0) begin
      fails++;
      $display("FAIL drop_px h=70 got %h/%b want ff/0", pix, opq);
    end
    $display("[TB] px h=70 -> %h/%b (dropped write)", pix, opq);
    do_write(9'd90, 8'h5A);
    do_swap(1'b0);
    for (int i = 0; i < 4; i++) begin
      pulse_px(hs[i], mid, pix, opq);
      tests++;
      if (pix !== ex[i] || opq !== (ex[i] != 8'hFF)) begin
        fails++;
        $display("FAIL drop_line_px h=%0d got %h/%b want %h/%b", hs[i], pix, opq, ex[i], ex[i] != 8'hFF);
      end
      $display("[TB] px h=%0d -> %h/%b", hs[i], pix, opq);
    end
  endtask

  task automatic test_reset_midop;
    logic [7:0] mid, pix;
    logic opq;
    int k = 0;
    do_write(9'd30, 8'h77);
    #2 RESET_N = 1'b0;
    #1;
    tests++;
    if (INIT_DONE !== 1'b0 || WR_READY !== 1'b0 || PIX_OUT !== 8'hFF || PIX_OPQ !== 1'b0) begin
      fails++;
      $display("FAIL midop_reset done=%b rdy=%b pix=%h opq=%b want 0/0/ff/0",
               INIT_DONE, WR_READY, PIX_OUT, PIX_OPQ);
    end
    @(negedge MCLK);
    RESET_N = 1'b1;
    while (INIT_DONE !== 1'b1 && k < 600) begin
      @(negedge MCLK);
      k++;
    end
    tests++;
    if (k != 512) begin
      fails++;
      $display("FAIL midop_init_len cycles=%0d want 512", k);
    end
    pulse_px(9'd30, mid, pix, opq);
    tests++;
    if (pix !== 8'hFF || opq !== 1'b0) begin
      fails++;
      $display("FAIL midop_px h=30 got %h/%b want ff/0", pix, opq);
    end
    $display("[TB] reset mid-op, re-init cycles=%0d, px h=30 -> %h/%b", k, pix, opq);
  endtask

  initial begin
    test_reset;
    test_blank_line;
    test_basic_write;
    test_priority;
    test_erase;
    test_swap_drop;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
